// File: rtl/dut_bus_initiator.sv
// Bus initiator: turns a one-at-a-time command stream into single guarded
// write/read handshakes on the DUT port, with a wait timeout and a held response.
module dut_bus_initiator #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 3,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] write_address,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  write_en,
    input  logic                  write_rdy,
    output logic [ADDR_WIDTH-1:0] read_address,
    output logic                  read_en,
    input  logic [DATA_WIDTH-1:0] read_data,
    input  logic                  read_rdy,
    output logic [15:0]           wr_count,
    output logic [15:0]           rd_count
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        RESP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timed_out;
    logic              abort;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        write_en   = 1'b0;
        read_en    = 1'b0;
        abort      = 1'b0;
        timed_out  = (TIMEOUT != 0) && (wait_cnt == WAIT_W'(TIMEOUT));
        // Nothing may handshake while reset is held; the command is simply dropped.
        if (!reset) begin
            unique case (state)
                IDLE: begin
                    cmd_ready = 1'b1;
                    if (cmd_valid) state_next = cmd_write ? WRITE : READ;
                end
                WRITE: begin
                    if (write_rdy) begin
                        write_en   = 1'b1;
                        state_next = RESP;
                    end else if (timed_out) begin
                        abort      = 1'b1;
                        state_next = RESP;
                    end
                end
                READ: begin
                    if (read_rdy) begin
                        read_en    = 1'b1;
                        state_next = RESP;
                    end else if (timed_out) begin
                        abort      = 1'b1;
                        state_next = RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    assign rsp_valid = (state == RESP);

    // Port address/data registers double as the command latch and hold between commands.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt      <= '0;
            write_address <= '0;
            write_data    <= '0;
            read_address  <= '0;
            rsp_data      <= '0;
            rsp_err       <= 1'b0;
            wr_count      <= '0;
            rd_count      <= '0;
        end else begin
            if (cmd_ready && cmd_valid) begin
                wait_cnt <= '0;
                if (cmd_write) begin
                    write_address <= cmd_addr;
                    write_data    <= cmd_wdata;
                end else begin
                    read_address <= cmd_addr;
                end
            end else if ((state == WRITE && !write_rdy) || (state == READ && !read_rdy)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if (write_en) begin
                wr_count <= wr_count + 16'd1;
                rsp_data <= '0;
                rsp_err  <= 1'b0;
            end
            if (read_en) begin
                rd_count <= rd_count + 16'd1;
                rsp_data <= read_data;
                rsp_err  <= 1'b0;
            end
            if (abort) begin
                rsp_data <= '0;
                rsp_err  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dut_bus_initiator.sv
// Directed bench for dut_bus_initiator: expected bus strobes and responses are
// queued at command issue and consumed by independent monitors.
module tb_dut_bus_initiator;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [2:0] cmd_addr;
    logic [0:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [0:0] rsp_data;
    logic       rsp_err;
    logic [2:0] write_address;
    logic [0:0] write_data;
    logic       write_en;
    logic       write_rdy;
    logic [2:0] read_address;
    logic       read_en;
    logic [0:0] read_data;
    logic       read_rdy;
    logic [15:0] wr_count;
    logic [15:0] rd_count;

    logic rd_val;
    logic rd_from_addr;
    int   cyc;
    int   passed;
    int   total;

    typedef struct {
        bit         wr;
        logic [2:0] addr;
        logic       d;
        int         cyc;
    } en_exp_t;

    typedef struct {
        logic d;
        logic err;
        int   cyc;
    } rsp_exp_t;

    en_exp_t  en_q[$];
    rsp_exp_t rsp_q[$];

    assign read_data = rd_from_addr ? read_address[0] : rd_val;

    dut_bus_initiator #(
        .DATA_WIDTH(1),
        .ADDR_WIDTH(3),
        .TIMEOUT   (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .write_address(write_address),
        .write_data   (write_data),
        .write_en     (write_en),
        .write_rdy    (write_rdy),
        .read_address (read_address),
        .read_en      (read_en),
        .read_data    (read_data),
        .read_rdy     (read_rdy),
        .wr_count     (wr_count),
        .rd_count     (rd_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        else passed++;
    endtask

    // Bus-side monitor: every strobe must match the next queued expectation.
    always @(negedge clk) begin
        en_exp_t e;
        if (!reset) begin
            if (write_en && read_en) check("en_overlap", 1, 0);
            if (write_en || read_en) begin
                if (en_q.size() == 0) begin
                    check("en_unexpected", 1, 0);
                end else begin
                    e = en_q.pop_front();
                    check("en_kind", write_en, e.wr);
                    check("en_cycle", cyc, e.cyc);
                    check("en_addr", write_en ? write_address : read_address, e.addr);
                    if (e.wr) check("en_wdata", write_data, e.d);
                end
            end
        end
    end

    // Response monitor: checks every cycle rsp_valid is up, pops on handshake.
    bit rsp_seen = 1'b0;
    always @(negedge clk) begin
        rsp_exp_t r;
        if (!reset && rsp_valid) begin
            if (rsp_q.size() == 0) begin
                check("rsp_unexpected", 1, 0);
            end else begin
                r = rsp_q[0];
                if (!rsp_seen) check("rsp_cycle", cyc, r.cyc);
                check("rsp_data", rsp_data, r.d);
                check("rsp_err", rsp_err, r.err);
                rsp_seen = 1'b1;
                if (rsp_ready) begin
                    void'(rsp_q.pop_front());
                    rsp_seen = 1'b0;
                end
            end
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the edge following acceptance.
    task automatic send(input bit w, input logic [2:0] a, input logic d,
                        input int en_dly, input logic ed, input logic ee, input int rsp_dly,
                        output int n);
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        n = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (cmd_ready) begin
                n = cyc;
                break;
            end
        end
        if (n < 0) begin
            check("cmd_accept_timeout", 0, 1);
        end else begin
            if (en_dly >= 0) en_q.push_back('{w, a, d, n + en_dly});
            if (rsp_dly >= 0) rsp_q.push_back('{ed, ee, n + rsp_dly});
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (rsp_q.size() == 0 && en_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("drain_timeout", 0, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_data"}, rsp_data, 0);
        check({tag, "_rsp_err"}, rsp_err, 0);
        check({tag, "_write_en"}, write_en, 0);
        check({tag, "_read_en"}, read_en, 0);
        check({tag, "_write_address"}, write_address, 0);
        check({tag, "_write_data"}, write_data, 0);
        check({tag, "_read_address"}, read_address, 0);
        check({tag, "_wr_count"}, wr_count, 0);
        check({tag, "_rd_count"}, rd_count, 0);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, expected end earlier", $time);
        $fatal(1);
    end

    initial begin
        int n;
        int prev;
        bit w;
        logic [2:0] a;
        logic d;

        passed = 0;
        total  = 0;
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b1; write_rdy = 1'b1; read_rdy = 1'b1; rd_val = 1'b0; rd_from_addr = 1'b0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check("reset_cmd_ready", cmd_ready, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");

        // Plain write: en at N+1, response at N+2.
        align();
        send(1'b1, 3'd4, 1'b1, 1, 1'b0, 1'b0, 2, n);
        wait_drain();
        check("write_wr_count", wr_count, 1);

        // Read with five stall cycles.
        align();
        read_rdy = 1'b0;
        rd_val   = 1'b1;
        send(1'b0, 3'd3, 1'b0, 6, 1'b1, 1'b0, 7, n);
        repeat (5) @(posedge clk);
        #1 read_rdy = 1'b1;
        wait_drain();
        check("read_rd_count", rd_count, 1);

        // Timeout abort: no strobe, error response at N+10.
        align();
        write_rdy = 1'b0;
        send(1'b1, 3'd1, 1'b1, -1, 1'b0, 1'b1, 10, n);
        wait_drain();
        check("abort_wr_count", wr_count, 1);
        check("abort_write_en", write_en, 0);

        // Ready arrives exactly when the wait counter reaches TIMEOUT.
        align();
        send(1'b1, 3'd2, 1'b1, 9, 1'b0, 1'b0, 10, n);
        repeat (8) @(posedge clk);
        #1 write_rdy = 1'b1;
        wait_drain();
        check("edge_wr_count", wr_count, 2);

        // Response backpressure.
        align();
        rsp_ready = 1'b0;
        send(1'b1, 3'd5, 1'b1, 1, 1'b0, 1'b0, 2, n);
        @(posedge clk);
        repeat (4) begin
            @(negedge clk);
            check("bp_cmd_ready", cmd_ready, 0);
            check("bp_rsp_valid", rsp_valid, 1);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        wait_drain();
        check("bp_wr_count", wr_count, 3);

        // Reset while a read waits on read_rdy.
        align();
        read_rdy = 1'b0;
        send(1'b0, 3'd6, 1'b0, -1, 1'b0, 1'b0, -1, n);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("midreset_cmd_ready", cmd_ready, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_all_zero("mid_reset");
        read_rdy = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("midreset_no_read_en", read_en, 0);
        end

        // Back-to-back alternating commands.
        rd_from_addr = 1'b1;
        align();
        prev = -1;
        for (int i = 0; i < 10; i++) begin
            w = (i % 2 == 0);
            a = 3'(i >> 1);
            d = 1'((i >> 1) % 2);
            send(w, a, d, 1, w ? 1'b0 : a[0], 1'b0, 2, n);
            if (prev >= 0) check("b2b_interval", n - prev, 3);
            prev = n;
        end
        wait_drain();
        check("b2b_wr_count", wr_count, 5);
        check("b2b_rd_count", rd_count, 5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
